// File: rtl/hd_skid_chain.sv
// Valid/ready pipeline of DEPTH full-throughput skid slices with flush and live occupancy.
// Latency: DEPTH cycles from accept to valid_output; 1 transfer/cycle sustained.
// Backpressure: every slice boundary is fully registered (ready = !skid_valid); holds 2*DEPTH entries.
module hd_skid_chain #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int CNT_WIDTH  = $clog2(2*DEPTH+1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] data_src,
    output logic                  ready_output,
    output logic                  valid_output,
    output logic [DATA_WIDTH-1:0] data_dest,
    input  logic                  ready,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  occupancy
);

    if (DEPTH < 1) begin : g_depth_check
        $error("hd_skid_chain: DEPTH must be at least 1");
    end

    // Per-slice views: main-register flags/data, skid flags, and the
    // upstream valid/data and downstream ready each slice sees.
    logic [DEPTH-1:0]      m_vld;
    logic [DEPTH-1:0]      s_vld;
    logic [DEPTH-1:0]      up_vld;
    logic [DEPTH-1:0]      dn_rdy;
    logic [DATA_WIDTH-1:0] m_dat  [DEPTH];
    logic [DATA_WIDTH-1:0] up_dat [DEPTH];

    logic                  acc;
    logic                  emit;
    logic [CNT_WIDTH-1:0]  occ;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slice
        logic                  mv;
        logic                  sv;
        logic [DATA_WIDTH-1:0] md;
        logic [DATA_WIDTH-1:0] sd;
        logic                  in_fire;
        logic                  out_fire;

        // Slice 0 is fed by the chain input; later slices by the previous main register.
        if (k == 0) begin : g_head
            assign up_vld[k] = valid;
            assign up_dat[k] = data_src;
        end else begin : g_link
            assign up_vld[k] = m_vld[k-1];
            assign up_dat[k] = m_dat[k-1];
        end

        // The last slice sees the consumer's ready; inner slices see the next slice's skid state.
        if (k == DEPTH-1) begin : g_tail
            assign dn_rdy[k] = ready;
        end else begin : g_mid
            assign dn_rdy[k] = ~s_vld[k+1];
        end

        assign in_fire  = up_vld[k] & ~sv;
        assign out_fire = mv & dn_rdy[k];

        // Main/skid update; skid drains into main before any new payload is taken into main.
        always_ff @(posedge clk) begin
            if (rst) begin
                mv <= 1'b0;
                sv <= 1'b0;
                md <= '0;
                sd <= '0;
            end else if (flush) begin
                mv <= 1'b0;
                sv <= 1'b0;
            end else if (out_fire && sv) begin
                // in_fire is impossible here: the upstream saw ready = 0.
                md <= sd;
                sv <= 1'b0;
            end else if (in_fire && (!mv || out_fire)) begin
                md <= up_dat[k];
                mv <= 1'b1;
            end else if (in_fire) begin
                sd <= up_dat[k];
                sv <= 1'b1;
            end else if (out_fire) begin
                mv <= 1'b0;
            end
        end

        assign m_vld[k] = mv;
        assign s_vld[k] = sv;
        assign m_dat[k] = md;
    end

    // Outputs are forced low while reset is held so nothing leaks out mid-reset.
    assign ready_output = ~s_vld[0] & ~rst;
    assign valid_output = m_vld[DEPTH-1] & ~rst;
    assign data_dest    = rst ? '0 : m_dat[DEPTH-1];
    assign occupancy    = rst ? '0 : occ;

    assign acc  = valid & ready_output;
    assign emit = valid_output & ready;

    // Occupancy tracks external handshakes only; internal slice moves do not change it.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ <= '0;
        end else begin
            occ <= occ + CNT_WIDTH'(acc) - CNT_WIDTH'(emit);
        end
    end

endmodule

// File: tb/tb_hd_skid_chain.sv
// Self-checking bench for hd_skid_chain: directed vector table plus corner-case sequences.
// A DEPTH=2/32-bit instance carries the directed work; a DEPTH=1/8-bit instance runs a random soak.
// Outputs are sampled 1 ns after the falling edge, inputs driven at the falling edge.
module tb_hd_skid_chain;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=2, DATA_WIDTH=32 instance
    logic        rst, valid, ready, flush;
    logic [31:0] data_src, data_dest;
    logic        ready_output, valid_output;
    logic [2:0]  occupancy;

    // DEPTH=1, DATA_WIDTH=8 instance
    logic        rst1, valid1, ready1, flush1;
    logic [7:0]  data_src1, data_dest1;
    logic        ready_output1, valid_output1;
    logic [1:0]  occupancy1;

    hd_skid_chain #(.DATA_WIDTH(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .valid(valid), .data_src(data_src),
        .ready_output(ready_output), .valid_output(valid_output),
        .data_dest(data_dest), .ready(ready), .flush(flush), .occupancy(occupancy)
    );

    hd_skid_chain #(.DATA_WIDTH(8), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst1), .valid(valid1), .data_src(data_src1),
        .ready_output(ready_output1), .valid_output(valid_output1),
        .data_dest(data_dest1), .ready(ready1), .flush(flush1), .occupancy(occupancy1)
    );

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        f;
        logic        e_vo;
        logic        e_dd_chk;
        logic [31:0] e_dd;
        logic        e_rdy;
        logic [2:0]  e_occ;
    } vec_t;

    vec_t        tbl [16];
    int          n_cmp, n_bad;
    logic [31:0] q  [$];
    logic [7:0]  q1 [$];
    int          cyc, n_emit;
    logic        last_acc, last_emt, last_vo;
    logic [31:0] last_dd;
    int          nxt, first_acc, first_vo, start_emit, cc, cnt, sz;
    logic        hold;
    logic [31:0] prev_dd;
    logic        got;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock of the DEPTH=2 instance, with a reference queue checking order and occupancy.
    task automatic tick();
        #1;
        last_acc = valid && ready_output;
        last_emt = valid_output && ready;
        last_vo  = valid_output;
        last_dd  = data_dest;
        chk("occ_vs_model", 64'(occupancy), rst ? 64'd0 : 64'(q.size()));
        if (last_emt) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_emit: got %0h, expected no output (cycle %0d)", data_dest, cyc);
            end else begin
                chk("emit_order", 64'(data_dest), 64'(q.pop_front()));
            end
            n_emit++;
        end
        if (last_acc) q.push_back(data_src);
        if (flush || rst) q.delete();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; n_emit = 0;
        rst = 1; valid = 0; ready = 0; flush = 0; data_src = 0;
        rst1 = 1; valid1 = 0; ready1 = 0; flush1 = 0; data_src1 = 0;

        //                v  d        r  f  | vo dd_chk dd      rdy occ
        tbl[0]  = '{H, 32'h01, H, L,   L, H, 32'h00, H, 3'd0};
        tbl[1]  = '{H, 32'h02, H, L,   L, L, 32'h00, H, 3'd1};
        tbl[2]  = '{H, 32'h03, H, L,   H, H, 32'h01, H, 3'd2};
        tbl[3]  = '{L, 32'h00, L, L,   H, H, 32'h02, H, 3'd2};
        tbl[4]  = '{H, 32'h04, L, L,   H, H, 32'h02, H, 3'd2};
        tbl[5]  = '{H, 32'h05, L, L,   H, H, 32'h02, H, 3'd3};
        tbl[6]  = '{H, 32'h06, L, L,   H, H, 32'h02, L, 3'd4};
        tbl[7]  = '{H, 32'h06, H, L,   H, H, 32'h02, L, 3'd4};
        tbl[8]  = '{H, 32'h06, H, L,   H, H, 32'h03, L, 3'd3};
        tbl[9]  = '{H, 32'h06, H, L,   H, H, 32'h04, H, 3'd2};
        tbl[10] = '{H, 32'h07, H, H,   H, H, 32'h05, H, 3'd2};
        tbl[11] = '{L, 32'h00, H, L,   L, L, 32'h00, H, 3'd0};
        tbl[12] = '{H, 32'h08, H, L,   L, L, 32'h00, H, 3'd0};
        tbl[13] = '{L, 32'h00, H, L,   L, L, 32'h00, H, 3'd1};
        tbl[14] = '{L, 32'h00, H, L,   H, H, 32'h08, H, 3'd1};
        tbl[15] = '{L, 32'h00, H, L,   L, L, 32'h00, H, 3'd0};

        @(negedge clk);
        // Reset state: everything low while rst is held
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rst_ready", 64'(ready_output), 64'd0);
            chk("rst_valid", 64'(valid_output), 64'd0);
            chk("rst_occ", 64'(occupancy), 64'd0);
            tick();
        end
        rst = 0;

        // Directed table
        for (int i = 0; i < 16; i++) begin
            valid = tbl[i].v; data_src = tbl[i].d; ready = tbl[i].r; flush = tbl[i].f;
            #1;
            chk($sformatf("vec%0d_valid", i), 64'(valid_output), 64'(tbl[i].e_vo));
            chk($sformatf("vec%0d_ready", i), 64'(ready_output), 64'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_occ", i), 64'(occupancy), 64'(tbl[i].e_occ));
            if (tbl[i].e_dd_chk)
                chk($sformatf("vec%0d_data", i), 64'(data_dest), 64'(tbl[i].e_dd));
            tick();
        end
        flush = 0; valid = 0;

        // Back-to-back stream 0x01..0x10 with ready held high
        ready = 1; nxt = 1; first_acc = -1; first_vo = -1; start_emit = n_emit;
        for (int c = 0; c < 40; c++) begin
            valid = (nxt <= 16); data_src = 32'(nxt);
            cc = cyc;
            tick();
            if (last_acc) begin
                if (first_acc < 0) first_acc = cc;
                nxt++;
            end
            if (last_emt && first_vo < 0) first_vo = cc;
            if (last_acc && last_emt) chk("t1_occ_steady", 64'(occupancy), 64'd2);
        end
        valid = 0;
        chk("t1_latency", 64'(first_vo - first_acc), 64'd2);
        chk("t1_count", 64'(n_emit - start_emit), 64'd16);

        // Stall: exactly four accepts, then full, then a bubble-free drain
        ready = 0; cnt = 0;
        for (int c = 0; c < 8; c++) begin
            valid = 1; data_src = 32'h20 + 32'(c);
            tick();
            if (last_acc) cnt++;
        end
        valid = 0;
        chk("t2_accepts", 64'(cnt), 64'd4);
        #1;
        chk("t2_full_ready", 64'(ready_output), 64'd0);
        chk("t2_full_occ", 64'(occupancy), 64'd4);
        ready = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t2_no_bubble", 64'(last_emt), 64'd1);
        end
        #1;
        chk("t2_empty_occ", 64'(occupancy), 64'd0);

        // Toggling ready, random valid: order and hold-stability
        hold = 0; prev_dd = 0; cnt = 0;
        for (int c = 0; c < 200; c++) begin
            ready = (c % 2 == 0);
            valid = 1'($urandom % 2);
            data_src = 32'h1000 + 32'(cnt);
            tick();
            if (hold) begin
                chk("t3_hold_valid", 64'(last_vo), 64'd1);
                chk("t3_hold_data", 64'(last_dd), 64'(prev_dd));
            end
            hold = last_vo && !ready;
            prev_dd = last_dd;
            if (last_acc) cnt++;
        end
        valid = 0; ready = 1;
        for (int c = 0; c < 10; c++) tick();
        chk("t3_drained", 64'(q.size()), 64'd0);

        // Flush at occupancy 3 with a concurrent accept of 0xAA
        ready = 0;
        for (int c = 0; c < 3; c++) begin
            valid = 1; data_src = 32'h41 + 32'(c);
            tick();
        end
        valid = 1; data_src = 32'hAA; flush = 1;
        #1;
        chk("t4_occ_before", 64'(occupancy), 64'd3);
        chk("t4_accepting", 64'(ready_output), 64'd1);
        tick();
        flush = 0; valid = 0;
        #1;
        chk("t4_occ_after", 64'(occupancy), 64'd0);
        chk("t4_valid_after", 64'(valid_output), 64'd0);
        ready = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t4_no_aa", 64'(last_vo), 64'd0);
        end

        // One-cycle reset with four entries held
        ready = 0;
        for (int c = 0; c < 4; c++) begin
            valid = 1; data_src = 32'h61 + 32'(c);
            tick();
        end
        valid = 0;
        #1;
        chk("t5_occ_full", 64'(occupancy), 64'd4);
        rst = 1;
        #1;
        chk("t5_rst_valid", 64'(valid_output), 64'd0);
        chk("t5_rst_ready", 64'(ready_output), 64'd0);
        chk("t5_rst_occ", 64'(occupancy), 64'd0);
        chk("t5_rst_data", 64'(data_dest), 64'd0);
        tick();
        rst = 0;
        #1;
        chk("t5_ready_after", 64'(ready_output), 64'd1);
        chk("t5_occ_after", 64'(occupancy), 64'd0);
        valid = 1; data_src = 32'h55; ready = 1;
        tick();
        valid = 0; got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (last_emt) begin
                got = 1;
                chk("t5_first_out", 64'(last_dd), 64'h55);
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL t5_timeout: got no output, expected 55");
        end

        // DEPTH=1 random soak
        @(negedge clk);
        rst1 = 0;
        for (int c = 0; c < 10000; c++) begin
            valid1 = 1'($urandom % 2);
            ready1 = 1'($urandom % 2);
            data_src1 = 8'($urandom);
            #1;
            sz = q1.size();
            chk("t6_occ_model", 64'(occupancy1), 64'(sz));
            chk("t6_occ_max", 64'(occupancy1 <= 2'd2), 64'd1);
            chk("t6_valid", 64'(valid_output1), 64'(sz > 0));
            chk("t6_ready", 64'(ready_output1), 64'(sz < 2));
            if (valid_output1 && ready1) begin
                if (sz == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL t6_spurious: got %0h, expected no output", data_dest1);
                end else begin
                    chk("t6_order", 64'(data_dest1), 64'(q1.pop_front()));
                end
            end
            if (valid1 && ready_output1) q1.push_back(data_src1);
            @(posedge clk);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
